mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/mc_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg -- shared types and constants for the multicycle controller.
//   state_e   : controller FSM states (4-bit encoding)
//   alu_op_e  : ALU operation class (ADD / SUB / FUNCT)
//   OP_*      : opcode field values, instr[31:26]
//   F_*       : funct field values, instr[5:0]
//   ALU_*     : alu_ctrl encodings driven to the ALU
// Optional feature: MC_ADDI_EN adds the ADDIEX/ADDIWB states.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
`ifdef MC_ADDI_EN
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
`endif
      S_JUMP     = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder -- combinational ALU control decode.
//   alu_op_i   : operation class from the controller FSM
//   funct_i    : instr[5:0], used only for the FUNCT class
//   alu_ctrl_o : ALU operation select
module alu_decoder
   import mc_pkg::*;
(
   input  alu_op_e    alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_ctrl_o = ALU_ADD;
         ALUOP_SUB: alu_ctrl_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               F_ADD:   alu_ctrl_o = ALU_ADD;
               F_SUB:   alu_ctrl_o = ALU_SUB;
               F_AND:   alu_ctrl_o = ALU_AND;
               F_OR:    alu_ctrl_o = ALU_OR;
               F_SLT:   alu_ctrl_o = ALU_SLT;
               default: alu_ctrl_o = ALU_ADD;  // unknown funct falls back to add
            endcase
         end
         default: alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller -- Moore FSM control unit for a multicycle MIPS subset
// (lw, sw, R-type, beq, j, optional addi).
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, funct     : instruction fields from the instruction register
//   zero              : ALU zero flag (qualifies beq)
//   alu_ctrl          : ALU operation select
//   alu_src_a/b       : ALU operand muxes
//   pc_src            : next-PC mux
//   pc_en, ir_write, mem_write, reg_write : write strobes
//   i_or_d, reg_dst, mem_to_reg           : datapath muxes
// Macro MC_ADDI_EN: when defined, opcode 001000 executes as addi;
// otherwise it is treated as an unknown opcode (NOP).
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alu_ctrl,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       i_or_d,
   output logic       reg_dst,
   output logic       mem_to_reg
);

   state_e     state_q, state_d;
   alu_op_e    alu_op;
   logic [2:0] alu_ctrl_s;
   logic       pc_write, branch;
   logic       alu_src_a_s, ir_write_s, mem_write_s, reg_write_s;
   logic       i_or_d_s, reg_dst_s, mem_to_reg_s;
   logic [1:0] alu_src_b_s, pc_src_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = S_FETCH;
      alu_op       = ALUOP_ADD;
      pc_write     = 1'b0;
      branch       = 1'b0;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = 2'b00;
      pc_src_s     = 2'b00;
      ir_write_s   = 1'b0;
      mem_write_s  = 1'b0;
      reg_write_s  = 1'b0;
      i_or_d_s     = 1'b0;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write_s  = 1'b1;
            pc_write    = 1'b1;
            alu_src_b_s = 2'b01;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b_s = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            state_d     = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            i_or_d_s = 1'b1;
            state_d  = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
         end
         S_MEMWRITE: begin
            i_or_d_s    = 1'b1;
            mem_write_s = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a_s = 1'b1;
            alu_op      = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            reg_dst_s   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_s = 1'b1;
            alu_op      = ALUOP_SUB;
            pc_src_s    = 2'b01;
            branch      = 1'b1;
         end
`ifdef MC_ADDI_EN
         S_ADDIEX: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_s = 1'b1;
         end
`endif
         S_JUMP: begin
            pc_src_s = 2'b10;
            pc_write = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i   (alu_op),
      .funct_i    (funct),
      .alu_ctrl_o (alu_ctrl_s)
   );

   // Reset holds the state at FETCH, whose outputs are non-zero; gate every
   // output with rst_n so nothing is driven while reset is asserted.
   assign pc_en      = rst_n & (pc_write | (branch & zero));
   assign ir_write   = rst_n & ir_write_s;
   assign mem_write  = rst_n & mem_write_s;
   assign reg_write  = rst_n & reg_write_s;
   assign i_or_d     = rst_n & i_or_d_s;
   assign reg_dst    = rst_n & reg_dst_s;
   assign mem_to_reg = rst_n & mem_to_reg_s;
   assign alu_src_a  = rst_n & alu_src_a_s;
   assign alu_src_b  = rst_n ? alu_src_b_s : '0;
   assign pc_src     = rst_n ? pc_src_s    : '0;
   assign alu_ctrl   = rst_n ? alu_ctrl_s  : '0;

endmodule
